seq_bit_serializer: RTL and testbench

- Upstream feeder for the scalable sequence detector.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out one bit per clock on `x`, qualified by `x_valid`, with word framing strobes.
- The default word width (8) matches a detector built with STATE_BITS=3.

---
 rtl/seq_bit_serializer.sv | 125 ++++++++++++
 tb/tb_seq_bit_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer: valid/ready input into a small FIFO, then one bit per
// unstalled clock on x with word_start/word_last framing.
module seq_bit_serializer #(
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned DEPTH     = 2,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                       clock0,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [WORD_BITS-1:0]       in_data,
    output logic                       in_ready,
    input  logic                       stall,
    output logic                       x,
    output logic                       x_valid,
    output logic                       word_start,
    output logic                       word_last,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(WORD_BITS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WORD_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     fill_q, fill_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 push, pop, fifo_empty, last_bit;

    // in_ready looks only at registered occupancy, never at a same-cycle pop
    assign in_ready   = (fill_q != LVL_W'(DEPTH));
    assign push       = in_valid & in_ready;
    assign fifo_empty = (fill_q == '0);
    assign last_bit   = (cnt_q == CNT_W'(WORD_BITS - 1));

    assign x_valid    = (state_q == ST_SHIFT) & ~stall;
    assign x          = x_valid & (MSB_FIRST ? shreg_q[WORD_BITS-1] : shreg_q[0]);
    assign word_start = x_valid & (cnt_q == '0);
    assign word_last  = x_valid & last_bit;
    assign busy       = (state_q == ST_SHIFT);
    assign fill_level = fill_q;

    // Shifter next state; the FIFO head is loaded on the last bit for zero-bubble output
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !stall) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!stall) begin
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        cnt_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = mem_q[rd_ptr_q];
                        end else begin
                            shreg_d = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fill_d = fill_q;
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + LVL_W'(1);
            2'b01:   fill_d = fill_q - LVL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid
    always_ff @(posedge clock0) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: LSB-first and MSB-first instances share stimulus and
// are checked every cycle against a word-queue reference model.
module tb_seq_bit_serializer;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 2;
    localparam int unsigned LW = $clog2(D) + 1;

    logic          clock0   = 1'b0;
    logic          reset_n  = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data  = '0;
    logic          stall    = 1'b0;

    logic          l_in_ready, l_x, l_x_valid, l_word_start, l_word_last, l_busy;
    logic [LW-1:0] l_fill_level;
    logic          m_in_ready, m_x, m_x_valid, m_word_start, m_word_last, m_busy;
    logic [LW-1:0] m_fill_level;

    int n_checks = 0;
    int n_fail   = 0;

    seq_bit_serializer #(.WORD_BITS(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clock0(clock0), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(l_in_ready), .stall(stall), .x(l_x), .x_valid(l_x_valid),
        .word_start(l_word_start), .word_last(l_word_last), .busy(l_busy),
        .fill_level(l_fill_level)
    );

    seq_bit_serializer #(.WORD_BITS(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_dut_msb (
        .clock0(clock0), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_in_ready), .stall(stall), .x(m_x), .x_valid(m_x_valid),
        .word_start(m_word_start), .word_last(m_word_last), .busy(m_busy),
        .fill_level(m_fill_level)
    );

    always #5 clock0 = ~clock0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queued words plus the word being sent and its remaining bit count
    logic [W-1:0] mdl_q[$];
    logic [W-1:0] mdl_cur = '0;
    int           mdl_rem = 0;
    int           mdl_sz;
    bit           mdl_push;

    always @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            mdl_q.delete();
            mdl_rem = 0;
            mdl_cur = '0;
        end else begin
            mdl_sz   = mdl_q.size();
            mdl_push = in_valid && (mdl_sz != D);
            if (!stall) begin
                if (mdl_rem > 0) mdl_rem--;
                if (mdl_rem == 0 && mdl_sz > 0) begin
                    mdl_cur = mdl_q.pop_front();
                    mdl_rem = W;
                end
            end
            if (mdl_push) mdl_q.push_back(in_data);
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clock0) begin
        bit exp_v, exp_lb, exp_mb;
        int k;
        exp_v  = (mdl_rem > 0) && !stall;
        k      = W - mdl_rem;
        exp_lb = exp_v && (mdl_rem > 0) && mdl_cur[k];
        exp_mb = exp_v && (mdl_rem > 0) && mdl_cur[W-1-k];
        check_eq("x_valid_l",    32'(l_x_valid),    32'(exp_v));
        check_eq("x_l",          32'(l_x),          32'(exp_lb));
        check_eq("word_start_l", 32'(l_word_start), 32'(exp_v && mdl_rem == W));
        check_eq("word_last_l",  32'(l_word_last),  32'(exp_v && mdl_rem == 1));
        check_eq("busy_l",       32'(l_busy),       32'(mdl_rem > 0));
        check_eq("fill_l",       32'(l_fill_level), 32'(mdl_q.size()));
        check_eq("in_ready_l",   32'(l_in_ready),   32'(mdl_q.size() != D));
        check_eq("x_valid_m",    32'(m_x_valid),    32'(exp_v));
        check_eq("x_m",          32'(m_x),          32'(exp_mb));
        check_eq("word_start_m", 32'(m_word_start), 32'(exp_v && mdl_rem == W));
        check_eq("word_last_m",  32'(m_word_last),  32'(exp_v && mdl_rem == 1));
        check_eq("busy_m",       32'(m_busy),       32'(mdl_rem > 0));
        check_eq("fill_m",       32'(m_fill_level), 32'(mdl_q.size()));
        check_eq("in_ready_m",   32'(m_in_ready),   32'(mdl_q.size() != D));
    end

    // Reassemble framed words from each serial stream; track longest x_valid run
    logic [W-1:0] words_l[$];
    logic [W-1:0] words_m[$];
    logic [W-1:0] acc_l = '0, acc_m = '0;
    int           pos_l = 0, pos_m = 0;
    int           run_cur = 0, run_max = 0;

    always @(negedge clock0) begin
        if (l_x_valid) begin
            if (l_word_start) begin acc_l = '0; pos_l = 0; end
            if (pos_l < W) acc_l[pos_l] = l_x;
            pos_l++;
            if (l_word_last) words_l.push_back(acc_l);
            run_cur++;
            if (run_cur > run_max) run_max = run_cur;
        end else begin
            run_cur = 0;
        end
        if (m_x_valid) begin
            if (m_word_start) begin acc_m = '0; pos_m = 0; end
            if (pos_m < W) acc_m[W-1-pos_m] = m_x;
            pos_m++;
            if (m_word_last) words_m.push_back(acc_m);
        end
    end

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        do begin
            ok = l_in_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok) check_eq("push_timeout", 32'(ok), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic pop_word_check(input string tag, input logic [W-1:0] e);
        check_eq({tag, "_avail_l"}, 32'(words_l.size() > 0), 32'(1));
        if (words_l.size() > 0) check_eq({tag, "_word_l"}, 32'(words_l.pop_front()), 32'(e));
        check_eq({tag, "_avail_m"}, 32'(words_m.size() > 0), 32'(1));
        if (words_m.size() > 0) check_eq({tag, "_word_m"}, 32'(words_m.pop_front()), 32'(e));
    endtask

    logic [W-1:0] sent[$];

    initial begin
        bit acc;
        // Reset and idle
        repeat (3) tick();
        check_eq("rst_fill",     32'(l_fill_level), 32'(0));
        check_eq("rst_in_ready", 32'(l_in_ready),   32'(1));
        check_eq("rst_busy",     32'(l_busy),       32'(0));
        reset_n = 1'b1;
        repeat (5) tick();
        check_eq("idle_x_valid", 32'(l_x_valid), 32'(0));
        check_eq("idle_x",       32'(l_x),       32'(0));

        // Single word latency and framing
        push_word(8'hB5);
        check_eq("lat_n_xv",     32'(l_x_valid),    32'(0));
        tick();
        check_eq("lat_n1_xv",    32'(l_x_valid),    32'(1));
        check_eq("lat_n1_start", 32'(l_word_start), 32'(1));
        repeat (7) tick();
        check_eq("lat_n8_last",  32'(l_word_last),  32'(1));
        check_eq("lat_n8_busy",  32'(l_busy),       32'(1));
        tick();
        check_eq("lat_n9_busy",  32'(l_busy),       32'(0));
        repeat (3) tick();
        pop_word_check("b5", 8'hB5);

        // Back-to-back words with no bubbles
        run_max = 0;
        push_word(8'h01);
        push_word(8'hFF);
        push_word(8'h80);
        repeat (30) tick();
        check_eq("b2b_run", 32'(run_max), 32'(24));
        pop_word_check("b2b0", 8'h01);
        pop_word_check("b2b1", 8'hFF);
        pop_word_check("b2b2", 8'h80);

        // Stall after the second bit
        push_word(8'hF0);
        repeat (3) tick();
        stall = 1'b1;
        tick();
        check_eq("stall_xv",   32'(l_x_valid), 32'(0));
        check_eq("stall_x",    32'(l_x),       32'(0));
        check_eq("stall_busy", 32'(l_busy),    32'(1));
        repeat (2) tick();
        stall = 1'b0;
        repeat (12) tick();
        pop_word_check("stall", 8'hF0);

        // Asynchronous reset mid-word with a full FIFO
        push_word(8'hA5);
        push_word(8'h5A);
        push_word(8'hC3);
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_xv_l",    32'(l_x_valid),    32'(0));
        check_eq("arst_x_l",     32'(l_x),          32'(0));
        check_eq("arst_busy_l",  32'(l_busy),       32'(0));
        check_eq("arst_fill_l",  32'(l_fill_level), 32'(0));
        check_eq("arst_rdy_l",   32'(l_in_ready),   32'(1));
        check_eq("arst_start_l", 32'(l_word_start), 32'(0));
        check_eq("arst_last_l",  32'(l_word_last),  32'(0));
        check_eq("arst_busy_m",  32'(m_busy),       32'(0));
        check_eq("arst_fill_m",  32'(m_fill_level), 32'(0));
        tick();
        reset_n = 1'b1;
        check_eq("arst_no_words", 32'(words_l.size()), 32'(0));
        push_word(8'h3C);
        repeat (14) tick();
        pop_word_check("post_rst", 8'h3C);
        check_eq("post_rst_stale_l", 32'(words_l.size()), 32'(0));
        check_eq("post_rst_stale_m", 32'(words_m.size()), 32'(0));

        // Random traffic; producer holds a word until it is accepted
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !acc)) begin
                in_valid = ($urandom % 2) == 1;
                in_data  = W'($urandom);
            end
            stall = ($urandom % 5) == 0;
            acc = in_valid && l_in_ready;
            if (acc) sent.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        repeat (40) tick();
        check_eq("rand_count_l", 32'(words_l.size()), 32'(sent.size()));
        check_eq("rand_count_m", 32'(words_m.size()), 32'(sent.size()));
        for (int i = 0; i < sent.size(); i++) begin
            if (i < words_l.size()) check_eq("rand_word_l", 32'(words_l[i]), 32'(sent[i]));
            if (i < words_m.size()) check_eq("rand_word_m", 32'(words_m[i]), 32'(sent[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
